// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types for the fetch controller
//   fetch_state_t : sequencer states
//   fetch_entry_t : fetch buffer entry {pc, instr} at the default widths
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam int unsigned DEF_PC_WIDTH    = 32;
  localparam int unsigned DEF_INSTR_WIDTH = 32;

  typedef struct packed {
    logic [DEF_PC_WIDTH-1:0]    pc;
    logic [DEF_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small FIFO with flush between fetch and decode
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : drop all entries (wins over push/pop)
//   push, push_data : write one entry
//   pop             : consume head (ignored when empty)
//   valid, head     : head entry valid / contents (0 when empty)
//   count           : entries held, 0..DEPTH
module fetch_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // The issue rule in the controller must keep a slot free for every fetch.
  always_ff @(posedge clk) begin
    if (rst_n && push && !flush) assert (count != FULL);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: PC control, imem handshake, fetch buffer
//   pc_out / pc_load / pc_inc / pc_target      : program counter interface
//   trap_* / branch_*                          : redirect sources, trap wins
//   halt_req / halted                          : stop issuing fetches
//   imem_req/addr/gnt/rvalid/rdata             : instruction memory port
//   inst_valid/ready/pc/data                   : buffered instructions to decode
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INC_AMOUNT  = 4,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned BUF_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_WIDTH-1:0]    pc_out,
  output logic                   pc_load,
  output logic                   pc_inc,
  output logic [PC_WIDTH-1:0]    pc_target,
  input  logic                   trap_valid,
  input  logic [PC_WIDTH-1:0]    trap_target,
  input  logic                   branch_valid,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   halt_req,
  output logic                   halted,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [PC_WIDTH-1:0]    inst_pc,
  output logic [INSTR_WIDTH-1:0] inst_data
);

  localparam int unsigned ENTRY_W = PC_WIDTH + INSTR_WIDTH;
  localparam int unsigned CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_t        state, state_next;
  logic                drop, drop_next;
  logic [PC_WIDTH-1:0] req_pc;
  logic                redir;
  logic                flush;
  logic                push;
  logic [CW-1:0]       count;
  logic [ENTRY_W-1:0]  head;

  assign redir     = trap_valid | branch_valid;
  assign flush     = redir && (state != BOOT);
  assign pc_target = (state == BOOT) ? '0 : (trap_valid ? trap_target : branch_target);
  assign {inst_pc, inst_data} = head;

  always_comb begin
    state_next = state;
    drop_next  = drop;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = '0;
    halted     = 1'b0;
    push       = 1'b0;
    case (state)
      BOOT: state_next = REQ;
      REQ: begin
        pc_load   = redir;
        // Only issue when the response is guaranteed a buffer slot.
        imem_req  = !redir && !halt_req && (count < DEPTH_C);
        imem_addr = pc_out;
        if (imem_req && imem_gnt) begin
          pc_inc     = 1'b1;
          state_next = WAIT;
        end else if (halt_req && !redir) begin
          state_next = HALT;
        end
      end
      WAIT: begin
        pc_load = redir;
        if (imem_rvalid) begin
          push       = !drop && !redir;
          drop_next  = 1'b0;
          state_next = (halt_req && !redir) ? HALT : REQ;
        end else if (redir) begin
          // Outstanding fetch now belongs to a stale path.
          drop_next = 1'b1;
        end
      end
      HALT: begin
        halted  = 1'b1;
        pc_load = redir;
        if (!halt_req) state_next = REQ;
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      drop   <= 1'b0;
      req_pc <= '0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (pc_inc) req_pc <= pc_out;
    end
  end

  // While a live fetch is outstanding the counter must sit one step past it.
  always_ff @(posedge clk) begin
    if (rst_n && state == WAIT && !drop && !redir)
      assert (pc_out == req_pc + PC_WIDTH'(INC_AMOUNT));
  end

  fetch_buffer #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data ({req_pc, imem_rdata}),
    .pop       (inst_ready),
    .valid     (inst_valid),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int PW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [PW-1:0] pc_out, pc_target, trap_target, branch_target, imem_addr, inst_pc;
  logic [IW-1:0] imem_rdata, inst_data;
  logic pc_load, pc_inc, trap_valid, branch_valid, halt_req, halted;
  logic imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready;

  fetch_ctrl #(.PC_WIDTH(PW), .INC_AMOUNT(4), .INSTR_WIDTH(IW), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .pc_load(pc_load), .pc_inc(pc_inc),
    .pc_target(pc_target), .trap_valid(trap_valid), .trap_target(trap_target),
    .branch_valid(branch_valid), .branch_target(branch_target), .halt_req(halt_req),
    .halted(halted), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: phase flags plus a queue of buffered {pc, instr}.
  bit            m_boot, m_busy, m_cancel, m_halt;
  logic [PW-1:0] m_pc, m_req_pc;
  fetch_entry_t  m_q[$];
  // Memory responder: one pending response after r_cnt cycles.
  bit            r_pend, force_rvalid;
  int            r_cnt, lat_cfg;
  // Expected values for the current cycle.
  bit            e_redir, e_load, e_req, e_inc;
  logic [PW-1:0] e_target;

  assign pc_out = m_pc;

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return a + 32'h13 - 32'h1000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic eval();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (force_rvalid) begin
      imem_rvalid  = 1'b1;
      imem_rdata   = 32'hDEAD_BEEF;
      force_rvalid = 1'b0;
    end else if (r_pend) begin
      if (r_cnt == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m_req_pc);
        r_pend      = 1'b0;
      end else r_cnt--;
    end
    #1;
    e_redir  = trap_valid | branch_valid;
    e_load   = !m_boot && e_redir;
    e_target = trap_valid ? trap_target : branch_target;
    e_req    = !m_boot && !m_busy && !m_halt && !e_redir && !halt_req && (m_q.size() < DEPTH);
    e_inc    = e_req && imem_gnt;
    chk("pc_load", pc_load, e_load);
    chk("pc_inc", pc_inc, e_inc);
    chk("imem_req", imem_req, e_req);
    chk("halted", halted, m_halt);
    chk("inst_valid", inst_valid, m_q.size() != 0);
    if (e_load) chk("pc_target", pc_target, e_target);
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    if (m_q.size() != 0) begin
      chk("inst_pc", inst_pc, m_q[0].pc);
      chk("inst_data", inst_data, m_q[0].instr);
    end
  endtask

  task automatic adv();
    fetch_entry_t e;
    bit popping;
    popping = (m_q.size() != 0) && inst_ready;
    @(posedge clk);
    #1;
    if (m_boot) m_boot = 1'b0;
    else begin
      if (e_redir) m_q.delete();
      else if (popping) void'(m_q.pop_front());
      if (m_busy) begin
        if (imem_rvalid) begin
          if (!m_cancel && !e_redir) begin
            e.pc = m_req_pc;
            e.instr = imem_rdata;
            m_q.push_back(e);
          end
          m_cancel = 1'b0;
          m_busy   = 1'b0;
          m_halt   = halt_req && !e_redir;
        end else if (e_redir) m_cancel = 1'b1;
      end else if (m_halt) begin
        if (!halt_req) m_halt = 1'b0;
      end else if (e_inc) begin
        m_busy   = 1'b1;
        m_req_pc = m_pc;
        r_pend   = 1'b1;
        r_cnt    = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 3));
      end else if (halt_req && !e_redir) m_halt = 1'b1;
    end
    if (e_load) m_pc = e_target;
    else if (e_inc) m_pc = m_pc + 32'd4;
  endtask

  task automatic cyc();
    eval();
    adv();
  endtask

  task automatic do_reset(input int cycles);
    trap_valid = 1'b0; branch_valid = 1'b0; branch_target = 32'h2000;
    rst_n = 1'b0;
    #1;
    chk("rst pc_load", pc_load, 1'b0);
    chk("rst pc_inc", pc_inc, 1'b0);
    chk("rst pc_target", pc_target, 32'h0);
    chk("rst imem_req", imem_req, 1'b0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst halted", halted, 1'b0);
    chk("rst inst_valid", inst_valid, 1'b0);
    chk("rst inst_pc", inst_pc, 32'h0);
    chk("rst inst_data", inst_data, 32'h0);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_boot = 1'b1; m_busy = 1'b0; m_cancel = 1'b0; m_halt = 1'b0;
    m_q.delete();
    r_pend = 1'b0;
    m_pc = 32'h1000; m_req_pc = '0;
  endtask

  initial begin
    trap_valid = 0; branch_valid = 0; trap_target = 0; branch_target = 32'h2000;
    halt_req = 0; imem_gnt = 1; imem_rvalid = 0; imem_rdata = 0; inst_ready = 1;
    force_rvalid = 0; lat_cfg = 1; m_pc = 32'h1000;
    #2;
    do_reset(2);

    // First fetch at 0x1000 with a 1-cycle memory.
    eval(); chk("A boot req", imem_req, 1'b0); adv();
    eval(); chk("A addr", imem_addr, 32'h1000); chk("A inc", pc_inc, 1'b1); adv();
    eval(); chk("A wait req", imem_req, 1'b0); adv();
    lat_cfg = 3;
    eval(); chk("A inst_pc", inst_pc, 32'h1000); chk("A inst_data", inst_data, 32'h13);
    chk("A next addr", imem_addr, 32'h1004); adv();

    // Branch while waiting; response two cycles later is dropped.
    branch_valid = 1; branch_target = 32'h2000;
    eval(); chk("B load", pc_load, 1'b1); chk("B target", pc_target, 32'h2000); adv();
    branch_valid = 0;
    cyc();
    cyc();
    imem_gnt = 0;
    eval(); chk("B addr", imem_addr, 32'h2000); chk("B empty", inst_valid, 1'b0); adv();

    // Trap beats branch.
    trap_valid = 1; trap_target = 32'h80; branch_valid = 1; branch_target = 32'h2000;
    eval(); chk("C target", pc_target, 32'h80); chk("C load", pc_load, 1'b1);
    chk("C inc", pc_inc, 1'b0); chk("C req", imem_req, 1'b0); adv();

    // Fill the buffer with decode stalled, then drain in order.
    trap_valid = 0; branch_target = 32'h1000;
    cyc();
    branch_valid = 0; imem_gnt = 1; lat_cfg = 1; inst_ready = 0;
    repeat (4) cyc();
    eval(); chk("D full req", imem_req, 1'b0); chk("D head", inst_pc, 32'h1000); adv();
    eval(); chk("D still full", imem_req, 1'b0); adv();
    inst_ready = 1;
    eval(); chk("D pop1", inst_pc, 32'h1000); adv();
    lat_cfg = 2;
    eval(); chk("D pop2", inst_pc, 32'h1004); chk("D resume", imem_req, 1'b1);
    chk("D resume addr", imem_addr, 32'h1008); adv();

    // Halt while a fetch is outstanding.
    halt_req = 1;
    eval(); chk("E wait req", imem_req, 1'b0); adv();
    cyc();
    eval(); chk("E halted", halted, 1'b1); chk("E no req", imem_req, 1'b0);
    chk("E pushed", inst_pc, 32'h1008); adv();
    cyc();
    halt_req = 0;
    cyc();
    lat_cfg = 1; inst_ready = 0;
    eval(); chk("E resume addr", imem_addr, 32'h100C); chk("E unhalted", halted, 1'b0); adv();

    // Reset in WAIT with one entry buffered; a stale response follows.
    cyc();
    lat_cfg = 3;
    cyc();
    eval(); chk("F one entry", inst_valid, 1'b1); adv();
    do_reset(1);
    force_rvalid = 1;
    eval(); chk("F boot req", imem_req, 1'b0); chk("F empty", inst_valid, 1'b0); adv();
    eval(); chk("F restart addr", imem_addr, 32'h1000); adv();

    // Randomised traffic against the model.
    lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      trap_valid    = ($urandom_range(0, 19) == 0);
      branch_valid  = ($urandom_range(0, 9) == 0);
      trap_target   = $urandom & ~32'h3;
      branch_target = $urandom & ~32'h3;
      if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
      inst_ready = ($urandom_range(0, 2) != 0);
      imem_gnt   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 699) == 0) do_reset(1 + $urandom_range(0, 1));
      else cyc();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer that drives the program counter's load/inc controls and owns the instruction-memory request handshake.
- Arbitrates PC redirect sources: trap beats branch.
- Drops responses from fetches cancelled by a redirect.
- Buffers fetched instructions, tagged with their PC, in a small FIFO toward decode.
- Sits between the program counter, the instruction memory port and the decode stage.

Parameters:
PC_WIDTH, 32, width of PC, targets and imem address.
INC_AMOUNT, 4, PC increment per granted fetch; must match the counter's increment.
INSTR_WIDTH, 32, width of fetched instruction word.
BUF_DEPTH, 2, fetch buffer entries; power of 2, at least 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc_out  in  PC_WIDTH  current PC from the program counter
pc_load  out  1  load PC with pc_target
pc_inc  out  1  advance PC by INC_AMOUNT
pc_target  out  PC_WIDTH  redirect value driven to the PC load input
trap_valid  in  1  trap redirect request
trap_target  in  PC_WIDTH  trap handler address
branch_valid  in  1  branch redirect request
branch_target  in  PC_WIDTH  branch target address
halt_req  in  1  level; stop issuing fetches
halted  out  1  controller is in HALT
imem_req  out  1  fetch request
imem_addr  out  PC_WIDTH  fetch address
imem_gnt  in  1  request accepted
imem_rvalid  in  1  response valid
imem_rdata  in  INSTR_WIDTH  response data
inst_valid  out  1  buffer head valid
inst_ready  in  1  decode accepts head
inst_pc  out  PC_WIDTH  PC of head instruction
inst_data  out  INSTR_WIDTH  head instruction

Behaviour:
- Reset: async assert, sync deassert at the integration level.
  - State = BOOT; buffer empty; drop flag = 0; req_pc = 0.
  - All outputs 0.
- The counter's stall input is tied low at integration. This block holds the PC by deasserting both pc_load and pc_inc.
- Redirect: redir = trap_valid | branch_valid. pc_target = trap_valid ? trap_target : branch_target. pc_load = redir in every state except BOOT.
- BOOT: one cycle, then REQ. A redirect in BOOT is ignored.
- REQ:
  - imem_req = !redir & !halt_req & (count < BUF_DEPTH); imem_addr = pc_out.
  - imem_req & imem_gnt: pc_inc = 1; req_pc <= pc_out; go to WAIT. Latency from grant to PC advance is 1 cycle.
  - halt_req (no redir): go to HALT.
  - imem_req may drop without a grant.
- WAIT: one fetch outstanding; imem_req = 0.
  - On imem_rvalid: push {req_pc, imem_rdata} unless the drop flag or redir is set; clear drop. Go to HALT if halt_req, else REQ.
  - redir without imem_rvalid: set drop, stay in WAIT.
  - redir with imem_rvalid in the same cycle: response dropped, go to REQ.
- HALT: halted = 1, no requests. A redirect loads the PC and stays in HALT. Leave to REQ when halt_req = 0.
- Buffer:
  - FIFO with wrap-around pointers and a count of 0..BUF_DEPTH.
  - inst_valid = count != 0. Pop on inst_valid & inst_ready.
  - Simultaneous push and pop keeps count unchanged.
  - redir flushes all entries in the same cycle; a pop that cycle is ignored.
  - Issue rule count < BUF_DEPTH, with a single outstanding fetch, guarantees a push never finds the buffer full. Assert no push when full.
- Throughput: one instruction per 2 cycles with a 1-cycle imem.
- Mid-operation reset: state returns to BOOT at once, buffer empties, any later imem_rvalid is ignored.
- pc_load and pc_inc are never both 1.

Decomposition:
- fetch_ctrl_pkg: state enum {BOOT, REQ, WAIT, HALT} and the buffer entry struct {pc, instr}.
- One sub-module: fetch_buffer, a parameterised FIFO with flush, push, pop, count and an async active-low reset.

Test Plan:
- Reset release, PC = 0x1000, imem grants immediately, rvalid the next cycle, rdata 0x13 -> imem_addr 0x1000, pc_inc pulses, inst_pc 0x1000 / inst_data 0x13, next request at 0x1004.
- branch_valid target 0x2000 while in WAIT, rvalid arrives 2 cycles later -> pc_load with pc_target 0x2000, response dropped, buffer empty, next imem_addr 0x2000.
- trap_valid (0x80) and branch_valid (0x2000) in the same cycle -> pc_target 0x80, only pc_load asserted.
- inst_ready held 0 with BUF_DEPTH 2 -> two instructions buffered, imem_req stays 0. inst_ready = 1 -> pops in order 0x1000 then 0x1004, fetching resumes.
- halt_req asserted in WAIT -> outstanding response pushed, halted = 1, no imem_req. Deassert -> REQ resumes at the current PC.
- rst_n pulsed low while in WAIT with 1 entry buffered -> outputs 0 at once, buffer empty, BOOT on release.
